// File: rtl/lpc_autocorr_ctrl.sv
// LPC autocorrelation sequencer: walks the frame buffer lag by lag, accumulates
// x[n]*x[n-k] through a three-stage MAC pipeline and writes saturated R[k] results.
module lpc_autocorr_ctrl #(
  parameter int N     = 160,
  parameter int ORDER = 10,
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int ACC_W = 40,
  parameter int SHIFT = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_lock,
  output logic [AW-1:0]        rd_addr_a,
  output logic [AW-1:0]        rd_addr_b,
  input  logic signed [DW-1:0] rd_data_a,
  input  logic signed [DW-1:0] rd_data_b,
  output logic                 r_wen,
  output logic [ORDER:0]       r_wsel,
  output logic [31:0]          r_din,
  output logic                 done
);

  localparam int KW = (ORDER < 1) ? 1 : $clog2(ORDER + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAG_INIT,
    S_MAC,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                     r_state;
  logic [KW-1:0]              r_k;
  logic [AW-1:0]              r_n;
  logic                       r_drain;
  logic                       r_vld_p1;
  logic                       r_vld_p2;
  logic signed [2*DW-1:0]     r_prod_p2;
  logic signed [ACC_W-1:0]    r_acc_p3;

  logic signed [2*DW-1:0]     w_a_ext;
  logic signed [2*DW-1:0]     w_b_ext;
  logic signed [ACC_W-1:0]    w_acc_nxt;

  // Scale down and clamp into signed 32-bit range.
  function automatic logic [31:0] sat32(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> SHIFT;
    if ((&s[ACC_W-1:31]) || (~|s[ACC_W-1:31]))
      return s[31:0];
    else if (s[ACC_W-1])
      return 32'h8000_0000;
    else
      return 32'h7FFF_FFFF;
  endfunction

  assign frame_lock = busy;

  // Stage 1 -> 2: read data returns, product registered
  assign w_a_ext = (2*DW)'(rd_data_a);
  assign w_b_ext = (2*DW)'(rd_data_b);

  always_ff @(posedge clk) begin
    r_prod_p2 <= w_a_ext * w_b_ext;
  end

  // Stage 2 -> 3: valid-tagged products accumulate
  assign w_acc_nxt = r_vld_p2 ? (r_acc_p3 + ACC_W'(r_prod_p2)) : r_acc_p3;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      busy      <= 1'b0;
      r_wen     <= 1'b0;
      done      <= 1'b0;
      r_wsel    <= '0;
      r_din     <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      r_acc_p3  <= '0;
      r_k       <= '0;
      r_n       <= '0;
      r_drain   <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
    end else begin
      r_vld_p1 <= (r_state == S_MAC);
      r_vld_p2 <= r_vld_p1;
      r_acc_p3 <= w_acc_nxt;
      r_wen    <= 1'b0;
      done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LAG_INIT;
            busy    <= 1'b1;
            r_k     <= '0;
          end
        end
        S_LAG_INIT: begin
          r_acc_p3  <= '0;
          r_n       <= AW'(r_k);
          rd_addr_a <= AW'(r_k);
          rd_addr_b <= '0;
          r_state   <= S_MAC;
        end
        S_MAC: begin
          if (r_n == AW'(N - 1)) begin
            r_state <= S_DRAIN;
            r_drain <= 1'b0;
          end else begin
            r_n       <= r_n + AW'(1);
            rd_addr_a <= r_n + AW'(1);
            rd_addr_b <= r_n + AW'(1) - AW'(r_k);
          end
        end
        S_DRAIN: begin
          // Second drain cycle sees the final product entering the accumulator.
          if (r_drain) begin
            r_state <= S_WRITE;
            r_wen   <= 1'b1;
            r_wsel  <= (ORDER + 1)'(1) << r_k;
            r_din   <= sat32(w_acc_nxt);
          end else begin
            r_drain <= 1'b1;
          end
        end
        S_WRITE: begin
          r_wsel <= '0;
          if (r_k == KW'(ORDER)) begin
            r_state <= S_DONE;
            done    <= 1'b1;
          end else begin
            r_k     <= r_k + KW'(1);
            r_state <= S_LAG_INIT;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_autocorr_ctrl.sv
// Bench for lpc_autocorr_ctrl: two instances (SHIFT=7 and SHIFT=0) share one frame
// buffer and are compared cycle by cycle against a plain-arithmetic autocorrelation model.
module tb_lpc_autocorr_ctrl;

  localparam int N     = 160;
  localparam int ORDER = 10;
  localparam int LAST  = 1750;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  logic signed [15:0] mem [256];

  logic        busy7, lock7, wen7, done7;
  logic [7:0]  a7, b7;
  logic signed [15:0] da7, db7;
  logic [10:0] wsel7;
  logic [31:0] din7;

  logic        busy0, lock0, wen0, done0;
  logic [7:0]  a0, b0;
  logic signed [15:0] da0, db0;
  logic [10:0] wsel0;
  logic [31:0] din0;

  lpc_autocorr_ctrl #(.SHIFT(7)) u_dut7 (
    .clk(clk), .reset(reset), .start(start), .busy(busy7), .frame_lock(lock7),
    .rd_addr_a(a7), .rd_addr_b(b7), .rd_data_a(da7), .rd_data_b(db7),
    .r_wen(wen7), .r_wsel(wsel7), .r_din(din7), .done(done7)
  );

  lpc_autocorr_ctrl #(.SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .frame_lock(lock0),
    .rd_addr_a(a0), .rd_addr_b(b0), .rd_data_a(da0), .rd_data_b(db0),
    .r_wen(wen0), .r_wsel(wsel0), .r_din(din0), .done(done0)
  );

  always @(posedge clk) begin
    da7 <= mem[a7];
    db7 <= mem[b7];
    da0 <= mem[a0];
    db0 <= mem[b0];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] ref_r(input int k, input int sh);
    longint s;
    longint maxv;
    longint minv;
    s    = 0;
    maxv = 64'sd2147483647;
    minv = -64'sd2147483648;
    for (int n = k; n < N; n++)
      s += longint'(mem[n]) * longint'(mem[n-k]);
    s = s >>> sh;
    if (s > maxv) return 32'h7FFF_FFFF;
    if (s < minv) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic set_frame(input int mode);
    for (int n = 0; n < 256; n++) begin
      case (mode)
        0: mem[n] = (n == 0) ? 16'sh0100 : 16'sh0000;
        1: mem[n] = 16'sh0001;
        2: mem[n] = (n % 2 == 0) ? 16'sh4000 : 16'shC000;
        3: mem[n] = 16'sh8000;
        4: mem[n] = 16'($urandom);
        default: mem[n] = 16'($urandom_range(0, 4095)) - 16'sd2048;
      endcase
    end
  endtask

  task automatic run(input int pulse_at, input int rst_at);
    logic [31:0] e7 [ORDER+1];
    logic [31:0] e0 [ORDER+1];
    int wcyc [ORDER+1];
    int lcyc [ORDER+1];
    int acc, last, lag, mk, dk;
    logic wexp;
    acc = 0;
    for (int k = 0; k <= ORDER; k++) begin
      acc    += N - k + 4;
      wcyc[k] = acc;
      lcyc[k] = acc - (N - k + 4) + 1;
      e7[k]   = ref_r(k, 7);
      e0[k]   = ref_r(k, 0);
    end
    last = (rst_at > 0) ? rst_at + 20 : LAST + 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      if (rst_at > 0 && c > rst_at) begin
        chk("rst_busy", busy7, 0);
        chk("rst_wen", {wen7, wen0}, 0);
        chk("rst_done", {done7, done0}, 0);
      end else begin
        lag = 0; mk = -1; dk = -1; wexp = 1'b0;
        for (int k = 0; k <= ORDER; k++) begin
          if (c == wcyc[k]) begin wexp = 1'b1; lag = k; end
          if (c > lcyc[k] && c <= lcyc[k] + N - k) mk = k;
          if (c > lcyc[k] + N - k && c < wcyc[k]) dk = k;
        end
        chk("busy", busy7, c <= LAST);
        chk("lock0", lock0, c <= LAST);
        chk("done", done7, c == LAST);
        chk("done0", done0, c == LAST);
        chk("wen", wen7, wexp);
        chk("wen0", wen0, wexp);
        if (wexp) begin
          chk("wsel", wsel7, 1 << lag);
          chk("wsel0", wsel0, 1 << lag);
          chk("din7", din7, e7[lag]);
          chk("din0", din0, e0[lag]);
        end else begin
          chk("wsel_idle", wsel7, 0);
        end
        if (mk >= 0) begin
          chk("addr_a", a7, mk + (c - lcyc[mk] - 1));
          chk("addr_b", b7, c - lcyc[mk] - 1);
        end
        if (dk >= 0) begin
          chk("drain_a", a7, N - 1);
          chk("drain_b", b7, N - 1 - dk);
        end
      end
      if (c == pulse_at) start = 1'b1;
      if (c == pulse_at + 1) start = 1'b0;
      if (c == rst_at) reset = 1'b0;
      if (c == rst_at + 1) reset = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    set_frame(0);
    repeat (3) @(negedge clk);
    chk("rst_state_busy", {busy7, busy0, lock7, lock0}, 0);
    chk("rst_state_wen", {wen7, wen0, done7, done0}, 0);
    chk("rst_state_wsel", {wsel7, wsel0}, 0);
    chk("rst_state_din", {din7, din0}, 0);
    chk("rst_state_addr", {a7, b7, a0, b0}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy7, 0);

    set_frame(0); run(0, 0);
    set_frame(1); run(0, 0);
    set_frame(2); run(300, 0);
    set_frame(3); run(0, 0);
    set_frame(4); run(0, 500);
    set_frame(4); run(0, 0);
    set_frame(5); run(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/lpc_autocorr_ctrl.md
Name: lpc_autocorr_ctrl

Overview:
Sequencer for the LPC autocorrelation stage. On `start` it walks the 160-sample frame buffer and computes R[k] = sum over n=k..N-1 of x[n]*x[n-k], for k = 0..ORDER. It drives two synchronous read ports into the frame buffer and feeds an internal multiply-accumulate pipeline. Each finished lag is written to the autocorrelation register file through `r_wen`/`r_wsel`/`r_din`. The block sits between the `x_*`-written frame buffer and the Levinson-Durbin stage of `lpc_encode`.

Parameters:
N, 160, frame length in samples (addresses 0..N-1)
ORDER, 10, highest lag computed; requires ORDER < N
AW, 8, frame buffer address width
DW, 16, sample width (signed two's complement)
ACC_W, 40, accumulator width (signed)
SHIFT, 7, right arithmetic shift applied to the accumulator before output

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  one-cycle request to process the current frame; accepted only in IDLE
busy  out  1  high in every state except IDLE
frame_lock  out  1  equals busy; the frame writer must hold x_wen low while this is high
rd_addr_a  out  AW  sample address n
rd_addr_b  out  AW  sample address n-k
rd_data_a  in  DW  x[rd_addr_a], valid 1 cycle after the address
rd_data_b  in  DW  x[rd_addr_b], valid 1 cycle after the address
r_wen  out  1  one-cycle write strobe for one lag result
r_wsel  out  ORDER+1  one-hot lag select; bit k = R[k]
r_din  out  32  scaled, saturated R[k]
done  out  1  one-cycle pulse after R[ORDER] is written

Behaviour:
- Reset values, applied while reset is 0 at a clock edge:
  - state = IDLE; busy, frame_lock, r_wen, done = 0
  - r_wsel, r_din, rd_addr_a, rd_addr_b = 0
  - accumulator, lag counter k, sample counter n and pipeline valid bits = 0
- States: IDLE, LAG_INIT, MAC, DRAIN, WRITE, DONE.
- IDLE: start = 1 → LAG_INIT with k = 0. start is ignored in every other state.
- LAG_INIT (1 cycle): clear the accumulator; set n = k → MAC.
- MAC (N-k cycles):
  - Each cycle: rd_addr_a = n, rd_addr_b = n-k, push a valid bit into the pipeline, then n++.
  - After the cycle that issued n = N-1 → DRAIN.
- Pipeline:
  - Stage 1: read data returns.
  - Stage 2: register the signed DWxDW product (2*DW bits).
  - Stage 3: acc += sign-extended product.
  - Only valid-tagged entries accumulate.
- DRAIN (2 cycles): no new addresses; rd_addr_a/b hold their last values; the pipeline empties → WRITE.
- WRITE (1 cycle):
  - r_wen = 1; r_wsel = 1 << k.
  - r_din = sat32(acc >>> SHIFT): clamp to 32'h7FFFFFFF or 32'h80000000 if out of signed 32-bit range.
  - If k == ORDER → DONE; else k++ → LAG_INIT.
- DONE (1 cycle): done = 1; busy still 1 → IDLE.
- r_wen and r_wsel are 0 outside WRITE. r_din holds its last written value.
- Timing:
  - Cycles per lag = N-k+4.
  - With defaults, done is high exactly 1750 cycles after the edge that sampled start (lags occupy cycles 1..1749, DONE is cycle 1750).
  - The next start is accepted in the cycle after DONE.
- Accumulator width rule: ACC_W ≥ 2*DW + ceil(log2 N); there is no overflow inside the accumulator.
- Reset mid-operation: return to IDLE at that edge. No further r_wen or done. Partial results in the register file are left as written.

Test Plan:
- Impulse: x[0] = 16'h0100, all others 0 → R0 = 32'd512, R1..R10 = 0. Eleven r_wen pulses with r_wsel 0x001, 0x002, ... 0x400 in order; done at cycle 1750.
- Constant: all x = 16'h0001 with SHIFT = 0 → R[k] = 160-k, i.e. 160, 159, ..., 150.
- Alternating: x[n] = 16'h4000 for even n, 16'hC000 for odd n (defaults) → R0 = 32'h14000000, R1 = 32'hEC200000, R2 = 32'h13C00000, R10 = 32'h12C00000.
- Saturation: all x = 16'h8000 with SHIFT = 0 → every R[k] = 32'h7FFFFFFF.
- Address sequence for lag 3: first MAC cycle a = 3, b = 0; last a = 159, b = 156. Exactly 157 MAC cycles, then 2 DRAIN cycles, then 1 WRITE cycle.
- Robustness:
  - start pulsed at cycle 300 → ignored; results and done timing unchanged.
  - reset = 0 at cycle 500 → busy = 0 and no r_wen afterwards.
  - A fresh start after reset → correct results, done 1750 cycles later.
